// File: rtl/bra_rs.sv
// bra_rs: branch reservation station in front of the branch execution unit.
// Holds ops until their operands arrive on the CDB; issues the oldest ready op per cycle.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module bra_rs #(
    parameter int DEPTH = 4,
    parameter int RW    = `ROB_ENTRY_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          disp_valid,
    input  logic [3:0]    disp_op,
    input  logic          disp_qj_w,
    input  logic [RW-1:0] disp_qj,
    input  logic [31:0]   disp_vj,
    input  logic          disp_qk_w,
    input  logic [RW-1:0] disp_qk,
    input  logic [31:0]   disp_vk,
    input  logic [31:0]   disp_pc,
    input  logic [31:0]   disp_off,
    input  logic [RW-1:0] disp_dest,
    output logic          rs_full,
    input  logic          cdb_valid,
    input  logic [RW-1:0] cdb_tag,
    input  logic [31:0]   cdb_val,
    output logic [3:0]    bra_op,
    output logic [31:0]   bra_srca,
    output logic [31:0]   bra_srcb,
    output logic [31:0]   bra_pc,
    output logic [31:0]   bra_off,
    output logic [RW-1:0] bra_dest
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] AGE_ONE = AW'(1);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_qj_w;
    logic [DEPTH-1:0] r_qk_w;
    logic [3:0]       r_op   [DEPTH];
    logic [RW-1:0]    r_qj   [DEPTH];
    logic [RW-1:0]    r_qk   [DEPTH];
    logic [31:0]      r_vj   [DEPTH];
    logic [31:0]      r_vk   [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_off  [DEPTH];
    logic [RW-1:0]    r_dest [DEPTH];
    logic [AW-1:0]    r_age  [DEPTH];

    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_cj_hit;
    logic [DEPTH-1:0] w_ck_hit;
    logic             w_sel_found;
    logic [AW-1:0]    w_sel_idx;
    logic [AW-1:0]    w_sel_age;
    logic [AW-1:0]    w_free_idx;
    logic             w_disp_fire;
    logic             w_dj_hit;
    logic             w_dk_hit;
    logic [AW-1:0]    w_age_nxt [DEPTH];

    assign rs_full     = &r_valid;
    assign w_disp_fire = disp_valid & ~rs_full & ~flush;
    assign w_dj_hit    = cdb_valid & disp_qj_w & (disp_qj == cdb_tag);
    assign w_dk_hit    = cdb_valid & disp_qk_w & (disp_qk == cdb_tag);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i]  = r_valid[i] & ~r_qj_w[i] & ~r_qk_w[i];
            w_cj_hit[i] = cdb_valid & r_valid[i] & r_qj_w[i]
                          & (r_qj[i] == cdb_tag);
            w_ck_hit[i] = cdb_valid & r_valid[i] & r_qk_w[i]
                          & (r_qk[i] == cdb_tag);
        end
    end

    // Oldest ready entry = largest age among ready entries.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ready[i] && (!w_sel_found || r_age[i] > w_sel_age)) begin
                w_sel_found = 1'b1;
                w_sel_idx   = AW'(i);
                w_sel_age   = r_age[i];
            end
        end
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = AW'(i);
            end
        end
    end

    // Entries older than the issued one step down so valid ages stay
    // dense (0..count-1) and can never wrap past DEPTH-1.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_age_nxt[i] = r_age[i];
            if (w_disp_fire) begin
                w_age_nxt[i] = w_age_nxt[i] + AGE_ONE;
            end
            if (w_sel_found && r_age[i] > w_sel_age) begin
                w_age_nxt[i] = w_age_nxt[i] - AGE_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_qj_w   <= '0;
            r_qk_w   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]   <= '0;
                r_qj[i]   <= '0;
                r_qk[i]   <= '0;
                r_vj[i]   <= '0;
                r_vk[i]   <= '0;
                r_pc[i]   <= '0;
                r_off[i]  <= '0;
                r_dest[i] <= '0;
                r_age[i]  <= '0;
            end
            bra_op   <= '0;
            bra_srca <= '0;
            bra_srcb <= '0;
            bra_pc   <= '0;
            bra_off  <= '0;
            bra_dest <= '0;
        end else if (flush) begin
            r_valid <= '0;
            bra_op  <= '0;
        end else begin
            if (w_sel_found) begin
                bra_op   <= r_op[w_sel_idx];
                bra_srca <= r_vj[w_sel_idx];
                bra_srcb <= r_vk[w_sel_idx];
                bra_pc   <= r_pc[w_sel_idx];
                bra_off  <= r_off[w_sel_idx];
                bra_dest <= r_dest[w_sel_idx];
                r_valid[w_sel_idx] <= 1'b0;
            end else begin
                bra_op <= '0;
            end

            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= w_age_nxt[i];
                if (w_cj_hit[i]) begin
                    r_vj[i]   <= cdb_val;
                    r_qj_w[i] <= 1'b0;
                end
                if (w_ck_hit[i]) begin
                    r_vk[i]   <= cdb_val;
                    r_qk_w[i] <= 1'b0;
                end
            end

            if (w_disp_fire) begin
                r_valid[w_free_idx] <= 1'b1;
                r_op[w_free_idx]    <= disp_op;
                r_qj_w[w_free_idx]  <= disp_qj_w & ~w_dj_hit;
                r_qj[w_free_idx]    <= disp_qj;
                r_vj[w_free_idx]    <= w_dj_hit ? cdb_val : disp_vj;
                r_qk_w[w_free_idx]  <= disp_qk_w & ~w_dk_hit;
                r_qk[w_free_idx]    <= disp_qk;
                r_vk[w_free_idx]    <= w_dk_hit ? cdb_val : disp_vk;
                r_pc[w_free_idx]    <= disp_pc;
                r_off[w_free_idx]   <= disp_off;
                r_dest[w_free_idx]  <= disp_dest;
                r_age[w_free_idx]   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bra_rs.sv
// tb_bra_rs: directed scenarios then random traffic for bra_rs,
// checked against an in-order queue model of the station.
module tb_bra_rs;

    localparam int DEPTH = 4;
    localparam int RW    = 4;

    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_BNE  = 4'd2;
    localparam logic [3:0] OP_JAL  = 4'd7;
    localparam logic [3:0] OP_JALR = 4'd8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          disp_valid;
    logic [3:0]    disp_op;
    logic          disp_qj_w;
    logic [RW-1:0] disp_qj;
    logic [31:0]   disp_vj;
    logic          disp_qk_w;
    logic [RW-1:0] disp_qk;
    logic [31:0]   disp_vk;
    logic [31:0]   disp_pc;
    logic [31:0]   disp_off;
    logic [RW-1:0] disp_dest;
    logic          rs_full;
    logic          cdb_valid;
    logic [RW-1:0] cdb_tag;
    logic [31:0]   cdb_val;
    logic [3:0]    bra_op;
    logic [31:0]   bra_srca;
    logic [31:0]   bra_srcb;
    logic [31:0]   bra_pc;
    logic [31:0]   bra_off;
    logic [RW-1:0] bra_dest;

    bra_rs #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_qj_w(disp_qj_w), .disp_qj(disp_qj), .disp_vj(disp_vj),
        .disp_qk_w(disp_qk_w), .disp_qk(disp_qk), .disp_vk(disp_vk),
        .disp_pc(disp_pc), .disp_off(disp_off), .disp_dest(disp_dest),
        .rs_full(rs_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .bra_op(bra_op), .bra_srca(bra_srca), .bra_srcb(bra_srcb),
        .bra_pc(bra_pc), .bra_off(bra_off), .bra_dest(bra_dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    op;
        bit            qj_w;
        logic [RW-1:0] qj;
        logic [31:0]   vj;
        bit            qk_w;
        logic [RW-1:0] qk;
        logic [31:0]   vk;
        logic [31:0]   pc;
        logic [31:0]   off;
        logic [RW-1:0] dest;
    } ent_t;

    // Pending ops in dispatch order: front is oldest.
    ent_t q[$];

    logic [3:0]    e_op   = '0;
    logic [31:0]   e_a    = '0;
    logic [31:0]   e_b    = '0;
    logic [31:0]   e_pc   = '0;
    logic [31:0]   e_off  = '0;
    logic [RW-1:0] e_dest = '0;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        flush      = 1'b0;
        disp_valid = 1'b0;
        disp_op    = '0;
        disp_qj_w  = 1'b0;
        disp_qj    = '0;
        disp_vj    = '0;
        disp_qk_w  = 1'b0;
        disp_qk    = '0;
        disp_vk    = '0;
        disp_pc    = '0;
        disp_off   = '0;
        disp_dest  = '0;
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_val    = '0;
    endtask

    task automatic set_disp(input logic [3:0] op, input bit qjw,
                            input logic [RW-1:0] qj, input logic [31:0] vj,
                            input bit qkw, input logic [RW-1:0] qk,
                            input logic [31:0] vk, input logic [31:0] pc,
                            input logic [31:0] off,
                            input logic [RW-1:0] dest);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_qj_w  = qjw;
        disp_qj    = qj;
        disp_vj    = vj;
        disp_qk_w  = qkw;
        disp_qk    = qk;
        disp_vk    = vk;
        disp_pc    = pc;
        disp_off   = off;
        disp_dest  = dest;
    endtask

    task automatic set_cdb(input logic [RW-1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_val   = val;
    endtask

    // Advance the model by one edge from the current inputs, clock, compare.
    task automatic step();
        int   sel;
        int   n0;
        ent_t e;
        n0 = q.size();
        if (!rst_n) begin
            q.delete();
            e_op = '0; e_a = '0; e_b = '0;
            e_pc = '0; e_off = '0; e_dest = '0;
        end else if (flush) begin
            q.delete();
            e_op = '0;
        end else begin
            sel = -1;
            foreach (q[i]) begin
                if (sel < 0 && !q[i].qj_w && !q[i].qk_w) sel = i;
            end
            if (sel >= 0) begin
                e_op = q[sel].op;   e_a = q[sel].vj;   e_b = q[sel].vk;
                e_pc = q[sel].pc;   e_off = q[sel].off;
                e_dest = q[sel].dest;
                q.delete(sel);
            end else begin
                e_op = '0;
            end
            foreach (q[i]) begin
                if (cdb_valid && q[i].qj_w && q[i].qj == cdb_tag) begin
                    q[i].vj = cdb_val; q[i].qj_w = 1'b0;
                end
                if (cdb_valid && q[i].qk_w && q[i].qk == cdb_tag) begin
                    q[i].vk = cdb_val; q[i].qk_w = 1'b0;
                end
            end
            if (disp_valid) begin
                check("disp_not_full", {31'b0, rs_full}, 32'd0);
                if (n0 < DEPTH) begin
                    e.op = disp_op; e.pc = disp_pc; e.off = disp_off;
                    e.dest = disp_dest;
                    e.qj = disp_qj; e.qk = disp_qk;
                    e.qj_w = disp_qj_w; e.vj = disp_vj;
                    e.qk_w = disp_qk_w; e.vk = disp_vk;
                    if (cdb_valid && e.qj_w && e.qj == cdb_tag) begin
                        e.qj_w = 1'b0; e.vj = cdb_val;
                    end
                    if (cdb_valid && e.qk_w && e.qk == cdb_tag) begin
                        e.qk_w = 1'b0; e.vk = cdb_val;
                    end
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        check("op",   {28'b0, bra_op}, {28'b0, e_op});
        check("srca", bra_srca, e_a);
        check("srcb", bra_srcb, e_b);
        check("pc",   bra_pc, e_pc);
        check("off",  bra_off, e_off);
        check("dest", {28'b0, bra_dest}, {28'b0, e_dest});
        check("full", {31'b0, rs_full}, {31'b0, (q.size() == DEPTH)});
    endtask

    initial begin
        logic [3:0] rop;
        bit         rqj;
        bit         rqk;
        idle();
        rst_n = 1'b0;
        step();
        step();
        check("rst_full", {31'b0, rs_full}, 32'd0);
        check("rst_op", {28'b0, bra_op}, 32'd0);
        rst_n = 1'b1;

        // Ready BEQ issues two edges after dispatch, for exactly one cycle.
        set_disp(OP_BEQ, 0, 0, 5, 0, 0, 5, 32'h100, 32'h20, 3);
        step();
        idle();
        step();
        check("t1_op", {28'b0, bra_op}, {28'b0, OP_BEQ});
        check("t1_srca", bra_srca, 32'd5);
        check("t1_srcb", bra_srcb, 32'd5);
        check("t1_dest", {28'b0, bra_dest}, 32'd3);
        step();
        check("t1_op_off", {28'b0, bra_op}, 32'd0);

        // Waiting operand woken by CDB issues the cycle after capture.
        set_disp(OP_BNE, 1, 7, 0, 0, 0, 1, 32'h200, 32'h8, 5);
        step();
        idle();
        step();
        set_cdb(7, 2);
        step();
        check("t2_capture_op", {28'b0, bra_op}, 32'd0);
        idle();
        step();
        check("t2_op", {28'b0, bra_op}, {28'b0, OP_BNE});
        check("t2_srca", bra_srca, 32'd2);
        check("t2_srcb", bra_srcb, 32'd1);

        // Dispatch-time bypass from the CDB.
        set_disp(OP_JALR, 1, 4, 0, 0, 0, 0, 32'h300, 32'h4, 6);
        set_cdb(4, 9);
        step();
        idle();
        step();
        check("t3_op", {28'b0, bra_op}, {28'b0, OP_JALR});
        check("t3_srca", bra_srca, 32'd9);
        step();

        // Fill all entries, wake together: issue follows dispatch order.
        for (int i = 0; i < DEPTH; i++) begin
            set_disp(OP_BEQ, 1, 10, 0, 0, 0, i, 32'h400 + i, 0, RW'(8 + i));
            step();
        end
        idle();
        check("t4_full", {31'b0, rs_full}, 32'd1);
        set_cdb(10, 32'h55);
        step();
        check("t4_full_capture", {31'b0, rs_full}, 32'd1);
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check("t4_order", {28'b0, bra_dest}, 32'(8 + i));
            check("t4_srca", bra_srca, 32'h55);
        end
        check("t4_full_drained", {31'b0, rs_full}, 32'd0);
        step();

        // Flush with a dispatch in the same cycle discards everything.
        for (int i = 0; i < 3; i++) begin
            set_disp(OP_BNE, 1, 12, 0, 0, 0, 0, 32'h500, 0, RW'(i));
            step();
        end
        set_disp(OP_JAL, 0, 0, 0, 0, 0, 0, 32'h600, 0, 4);
        set_cdb(12, 1);
        flush = 1'b1;
        step();
        check("t5_full", {31'b0, rs_full}, 32'd0);
        check("t5_op", {28'b0, bra_op}, 32'd0);
        idle();
        set_cdb(12, 1);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_issue", {28'b0, bra_op}, 32'd0);
        end

        // Reset while two entries are ready.
        set_disp(OP_BEQ, 1, 13, 0, 0, 0, 3, 32'h700, 32'h10, 1);
        step();
        set_disp(OP_BNE, 1, 13, 0, 0, 0, 4, 32'h704, 32'h10, 2);
        step();
        idle();
        set_cdb(13, 7);
        step();
        idle();
        rst_n = 1'b0;
        step();
        check("t6_op", {28'b0, bra_op}, 32'd0);
        check("t6_srca", bra_srca, 32'd0);
        check("t6_pc", bra_pc, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_issue", {28'b0, bra_op}, 32'd0);
        end

        // Random traffic against the queue model.
        for (int c = 0; c < 1500; c++) begin
            idle();
            rst_n = ($urandom_range(0, 255) != 0);
            flush = ($urandom_range(0, 63) == 0);
            if (q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                rop = 4'($urandom_range(1, 8));
                rqj = ($urandom_range(0, 1) == 1) && rop != OP_JAL;
                rqk = ($urandom_range(0, 1) == 1) && rop != OP_JAL
                      && rop != OP_JALR;
                set_disp(rop, rqj, RW'($urandom_range(0, 7)), $urandom,
                         rqk, RW'($urandom_range(0, 7)), $urandom,
                         $urandom, $urandom, RW'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 2) == 0) begin
                set_cdb(RW'($urandom_range(0, 7)), $urandom);
            end
            step();
        end
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
